// File: rtl/pu_multiplexer_sched_pkg.sv
// Shared definitions for the multiplexer scheduler: FSM state and op encodings.
package pu_multiplexer_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SEL  = 3'd1,
      ST_WR   = 3'd2,
      ST_RD   = 3'd3,
      ST_CAP  = 3'd4
   } state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

endpackage

// File: rtl/pu_multiplexer.sv
// Slot multiplexer shared by the scheduler: a selector strobe latches the slot
// index from data_in, a data strobe writes the selected slot, and an output
// strobe registers the selected slot onto data_out/attr_out.
module pu_multiplexer #(
   parameter int DATA_WIDTH = 32,
   parameter int ATTR_WIDTH = 4,
   parameter int SEL_WIDTH  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sel_active,
   input  logic                  data_active,
   input  logic                  out_active,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ATTR_WIDTH-1:0] attr_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [ATTR_WIDTH-1:0] attr_out
);

   localparam int NSLOT = 2 ** SEL_WIDTH;

   logic [SEL_WIDTH-1:0]  sel_q;
   logic [DATA_WIDTH-1:0] data_mem_q [NSLOT];
   logic [ATTR_WIDTH-1:0] attr_mem_q [NSLOT];
   logic [DATA_WIDTH-1:0] data_out_q;
   logic [ATTR_WIDTH-1:0] attr_out_q;

   // Selector latch, slot storage and registered output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q      <= '0;
         data_out_q <= '0;
         attr_out_q <= '0;
         for (int i = 0; i < NSLOT; i++) begin
            data_mem_q[i] <= '0;
            attr_mem_q[i] <= '0;
         end
      end else begin
         if (sel_active) begin
            sel_q <= data_in[SEL_WIDTH-1:0];
         end
         if (data_active) begin
            data_mem_q[sel_q] <= data_in;
            attr_mem_q[sel_q] <= attr_in;
         end
         if (out_active) begin
            data_out_q <= data_mem_q[sel_q];
            attr_out_q <= attr_mem_q[sel_q];
         end
      end
   end

   assign data_out = data_out_q;
   assign attr_out = attr_out_q;

endmodule

// File: rtl/pu_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the pointer and wraps.
module pu_rr_arbiter #(
   parameter int NREQ     = 2,
   parameter int ID_WIDTH = 1
) (
   input  logic [NREQ-1:0]     req_i,
   input  logic [ID_WIDTH-1:0] ptr_i,
   input  logic                enable_i,
   output logic [NREQ-1:0]     grant_o
);

   int   idx_s;
   logic found_s;

   // First requester after the pointer wins; at most one grant bit is set.
   always_comb begin
      grant_o = '0;
      found_s = 1'b0;
      idx_s   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx_s = (int'(ptr_i) + k) % NREQ;
         if (enable_i && !found_s && req_i[idx_s]) begin
            grant_o[idx_s] = 1'b1;
            found_s        = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/pu_multiplexer_sched.sv
// Round-robin scheduler turning whole read/write transactions from NREQ
// requesters into the strobe sequence of one shared pu_multiplexer.
module pu_multiplexer_sched
   import pu_multiplexer_sched_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ATTR_WIDTH = 4,
   parameter int SEL_WIDTH  = 1,
   parameter int NREQ       = 2,
   parameter int ID_WIDTH   = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req,
   input  logic [NREQ-1:0]            req_wr,
   input  logic [NREQ*SEL_WIDTH-1:0]  req_sel,
   input  logic [NREQ*DATA_WIDTH-1:0] req_data,
   input  logic [NREQ*ATTR_WIDTH-1:0] req_attr,
   output logic [NREQ-1:0]            grant,
   output logic                       busy,
   output logic                       done,
   output logic [ID_WIDTH-1:0]        done_id,
   output logic [DATA_WIDTH-1:0]      rd_data,
   output logic [ATTR_WIDTH-1:0]      rd_attr,
   output logic                       mux_sel_active,
   output logic                       mux_data_active,
   output logic                       mux_out_active,
   output logic [DATA_WIDTH-1:0]      mux_data_in,
   output logic [ATTR_WIDTH-1:0]      mux_attr_in,
   input  logic [DATA_WIDTH-1:0]      mux_data_out,
   input  logic [ATTR_WIDTH-1:0]      mux_attr_out
);

   state_e                state_q, state_d;
   logic [ID_WIDTH-1:0]   ptr_q;
   op_e                   op_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [ATTR_WIDTH-1:0] attr_q;
   logic [ID_WIDTH-1:0]   id_q;

   logic [NREQ-1:0]       arb_grant_s;
   logic [ID_WIDTH-1:0]   win_id_s;
   logic [SEL_WIDTH-1:0]  win_sel_s;

   logic                  sel_active_q, data_active_q, out_active_q;
   logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
   logic [ATTR_WIDTH-1:0] attr_in_q, attr_in_d;
   logic                  busy_q, done_q;
   logic [ID_WIDTH-1:0]   done_id_q;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic [ATTR_WIDTH-1:0] rd_attr_q;

   // Arbitration only happens in IDLE, and never while reset is held.
   pu_rr_arbiter #(
      .NREQ     (NREQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_arb (
      .req_i    (req),
      .ptr_i    (ptr_q),
      .enable_i ((state_q == ST_IDLE) && !rst),
      .grant_o  (arb_grant_s)
   );

   // One-hot grant to winner index, plus the winner's slot index.
   always_comb begin
      win_id_s = '0;
      for (int i = 0; i < NREQ; i++) begin
         win_id_s = win_id_s | (arb_grant_s[i] ? ID_WIDTH'(i) : '0);
      end
      win_sel_s = req_sel[int'(win_id_s)*SEL_WIDTH +: SEL_WIDTH];
   end

   // Next-state logic for the transaction sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (|arb_grant_s) begin
               state_d = ST_SEL;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEL:  state_d = (op_q == OP_WR) ? ST_WR : ST_RD;
         ST_WR:   state_d = ST_IDLE;
         ST_RD:   state_d = ST_CAP;
         ST_CAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Mux bus values for the upcoming state; SEL is only entered from IDLE,
   // so its slot index comes straight from the winner being latched.
   always_comb begin
      data_in_d = '0;
      attr_in_d = '0;
      case (state_d)
         ST_SEL: begin
            data_in_d = DATA_WIDTH'(win_sel_s);
         end
         ST_WR: begin
            data_in_d = data_q;
            attr_in_d = attr_q;
         end
         default: begin
            data_in_d = '0;
            attr_in_d = '0;
         end
      endcase
   end

   // State register, round-robin pointer and per-transaction latches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= ID_WIDTH'(NREQ - 1);
         op_q    <= OP_RD;
         data_q  <= '0;
         attr_q  <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         if (|arb_grant_s) begin
            ptr_q  <= win_id_s;
            op_q   <= op_e'(req_wr[win_id_s]);
            data_q <= req_data[int'(win_id_s)*DATA_WIDTH +: DATA_WIDTH];
            attr_q <= req_attr[int'(win_id_s)*ATTR_WIDTH +: ATTR_WIDTH];
            id_q   <= win_id_s;
         end
      end
   end

   // Registered strobes, bus, status, completion and captured read result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_active_q  <= 1'b0;
         data_active_q <= 1'b0;
         out_active_q  <= 1'b0;
         data_in_q     <= '0;
         attr_in_q     <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         done_id_q     <= '0;
         rd_data_q     <= '0;
         rd_attr_q     <= '0;
      end else begin
         sel_active_q  <= (state_d == ST_SEL);
         data_active_q <= (state_d == ST_WR);
         out_active_q  <= (state_d == ST_RD);
         data_in_q     <= data_in_d;
         attr_in_q     <= attr_in_d;
         busy_q        <= (state_d != ST_IDLE);
         done_q        <= (state_q == ST_WR) || (state_q == ST_CAP);
         if ((state_q == ST_WR) || (state_q == ST_CAP)) begin
            done_id_q <= id_q;
         end
         if (state_q == ST_CAP) begin
            rd_data_q <= mux_data_out;
            rd_attr_q <= mux_attr_out;
         end
      end
   end

   assign grant           = arb_grant_s;
   assign busy            = busy_q;
   assign done            = done_q;
   assign done_id         = done_id_q;
   assign rd_data         = rd_data_q;
   assign rd_attr         = rd_attr_q;
   assign mux_sel_active  = sel_active_q;
   assign mux_data_active = data_active_q;
   assign mux_out_active  = out_active_q;
   assign mux_data_in     = data_in_q;
   assign mux_attr_in     = attr_in_q;

endmodule

// File: tb/tb_pu_multiplexer_sched.sv
// Directed bench: scheduler driving a real pu_multiplexer.
module tb_pu_multiplexer_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req, req_wr, req_sel;
   logic [63:0] req_data;
   logic [7:0]  req_attr;
   logic [1:0]  grant;
   logic        busy, done;
   logic [0:0]  done_id;
   logic [31:0] rd_data;
   logic [3:0]  rd_attr;
   logic        mux_sel_active, mux_data_active, mux_out_active;
   logic [31:0] mux_data_in, mux_data_out;
   logic [3:0]  mux_attr_in, mux_attr_out;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   pu_multiplexer_sched #(
      .DATA_WIDTH(32), .ATTR_WIDTH(4), .SEL_WIDTH(1), .NREQ(2), .ID_WIDTH(1)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_sel(req_sel),
      .req_data(req_data), .req_attr(req_attr), .grant(grant), .busy(busy),
      .done(done), .done_id(done_id), .rd_data(rd_data), .rd_attr(rd_attr),
      .mux_sel_active(mux_sel_active), .mux_data_active(mux_data_active),
      .mux_out_active(mux_out_active), .mux_data_in(mux_data_in),
      .mux_attr_in(mux_attr_in), .mux_data_out(mux_data_out),
      .mux_attr_out(mux_attr_out)
   );

   pu_multiplexer #(.DATA_WIDTH(32), .ATTR_WIDTH(4), .SEL_WIDTH(1)) u_mux (
      .clk(clk), .rst(rst), .sel_active(mux_sel_active),
      .data_active(mux_data_active), .out_active(mux_out_active),
      .data_in(mux_data_in), .attr_in(mux_attr_in),
      .data_out(mux_data_out), .attr_out(mux_attr_out)
   );

   task automatic step;
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input int id, input logic wr, input logic sel,
                        input logic [31:0] data, input logic [3:0] attr);
      req_wr[id]           = wr;
      req_sel[id]          = sel;
      req_data[id*32 +: 32] = data;
      req_attr[id*4 +: 4]   = attr;
      req[id]              = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1; req = '0; req_wr = '0; req_sel = '0; req_data = '0; req_attr = '0;
      #2;
      n_total++;
      if ({grant, busy, done, done_id, rd_data, rd_attr} !== '0) begin
         $display("FAIL reset_status: got grant=%b busy=%b done=%b id=%b rd=%h/%h, want all 0",
                  grant, busy, done, done_id, rd_data, rd_attr);
      end else n_pass++;
      n_total++;
      if ({mux_sel_active, mux_data_active, mux_out_active, mux_data_in, mux_attr_in} !== '0) begin
         $display("FAIL reset_mux: got sel=%b dat=%b out=%b din=%h ain=%h, want all 0",
                  mux_sel_active, mux_data_active, mux_out_active, mux_data_in, mux_attr_in);
      end else n_pass++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_write;
      step;
      issue(0, 1'b1, 1'b0, 32'hAAAA_AAAA, 4'hA);
      #1;
      n_total++;
      if (grant !== 2'b01) $display("FAIL wr_grant: got %b want 01", grant); else n_pass++;
      step; req = '0;
      n_total++;
      if (mux_sel_active !== 1'b1 || mux_data_active !== 1'b0)
         $display("FAIL wr_sel_strobe: got sel=%b dat=%b want 1/0", mux_sel_active, mux_data_active);
      else n_pass++;
      n_total++;
      if (mux_data_in !== 32'h0 || busy !== 1'b1)
         $display("FAIL wr_sel_bus: got din=%h busy=%b want 0/1", mux_data_in, busy);
      else n_pass++;
      step;
      n_total++;
      if (mux_data_active !== 1'b1 || mux_data_in !== 32'hAAAA_AAAA || mux_attr_in !== 4'hA)
         $display("FAIL wr_data: got act=%b din=%h ain=%h want 1/AAAAAAAA/A",
                  mux_data_active, mux_data_in, mux_attr_in);
      else n_pass++;
      step;
      n_total++;
      if (done !== 1'b1 || done_id !== 1'b0 || mux_data_active !== 1'b0 || busy !== 1'b0)
         $display("FAIL wr_done: got done=%b id=%b act=%b busy=%b want 1/0/0/0",
                  done, done_id, mux_data_active, busy);
      else n_pass++;
   endtask

   task automatic test_write_read;
      step;
      issue(1, 1'b1, 1'b1, 32'h5555_5555, 4'h5);
      #1;
      n_total++;
      if (grant !== 2'b10) $display("FAIL wr1_grant: got %b want 10", grant); else n_pass++;
      step; req = '0;
      step; step;
      n_total++;
      if (done !== 1'b1 || done_id !== 1'b1)
         $display("FAIL wr1_done: got done=%b id=%b want 1/1", done, done_id);
      else n_pass++;
      issue(1, 1'b0, 1'b1, 32'h0, 4'h0);
      #1;
      n_total++;
      if (grant !== 2'b10) $display("FAIL rd1_grant: got %b want 10", grant); else n_pass++;
      step; req = '0;
      step;
      n_total++;
      if (mux_out_active !== 1'b1 || mux_data_in !== 32'h0)
         $display("FAIL rd1_out: got out=%b din=%h want 1/0", mux_out_active, mux_data_in);
      else n_pass++;
      step;
      n_total++;
      if (done !== 1'b0 || mux_out_active !== 1'b0)
         $display("FAIL rd1_cap: got done=%b out=%b want 0/0", done, mux_out_active);
      else n_pass++;
      step;
      n_total++;
      if (done !== 1'b1 || done_id !== 1'b1 || rd_data !== 32'h5555_5555 || rd_attr !== 4'h5)
         $display("FAIL rd1_result: got done=%b id=%b rd=%h/%h want 1/1/55555555/5",
                  done, done_id, rd_data, rd_attr);
      else n_pass++;
   endtask

   task automatic test_isolation;
      step;
      issue(0, 1'b0, 1'b0, 32'h0, 4'h0);
      #1;
      step; req = '0;
      step; step; step;
      n_total++;
      if (done !== 1'b1 || rd_data !== 32'hAAAA_AAAA || rd_attr !== 4'hA)
         $display("FAIL iso_rd0: got done=%b rd=%h/%h want 1/AAAAAAAA/A", done, rd_data, rd_attr);
      else n_pass++;
      issue(1, 1'b1, 1'b1, 32'h1234_5678, 4'h3);
      #1;
      step; req = '0;
      step; step;
      n_total++;
      if (done !== 1'b1 || done_id !== 1'b1 || rd_data !== 32'hAAAA_AAAA || rd_attr !== 4'hA)
         $display("FAIL iso_hold: got done=%b id=%b rd=%h/%h want 1/1/AAAAAAAA/A",
                  done, done_id, rd_data, rd_attr);
      else n_pass++;
      issue(1, 1'b0, 1'b1, 32'h0, 4'h0);
      #1;
      step; req = '0;
      step; step; step;
      n_total++;
      if (done !== 1'b1 || rd_data !== 32'h1234_5678 || rd_attr !== 4'h3)
         $display("FAIL iso_rd1: got done=%b rd=%h/%h want 1/12345678/3", done, rd_data, rd_attr);
      else n_pass++;
   endtask

   task automatic test_contention;
      int ng = 0;
      int nd = 0;
      int last_g = 0;
      logic [1:0] exp_g;
      logic [0:0] exp_d;
      step;
      issue(0, 1'b1, 1'b0, 32'h0000_0011, 4'h1);
      issue(1, 1'b1, 1'b1, 32'h0000_0022, 4'h2);
      for (int i = 0; i < 20; i++) begin
         #1;
         if (grant !== 2'b00) begin
            exp_g = (ng % 2 == 0) ? 2'b01 : 2'b10;
            n_total++;
            if (grant !== exp_g) $display("FAIL rr_grant%0d: got %b want %b", ng, grant, exp_g);
            else n_pass++;
            if (ng > 0) begin
               n_total++;
               if (i - last_g != 3) $display("FAIL rr_spacing%0d: got %0d want 3", ng, i - last_g);
               else n_pass++;
            end
            last_g = i;
            ng++;
         end
         if (done === 1'b1) begin
            exp_d = (nd % 2 == 0) ? 1'b0 : 1'b1;
            n_total++;
            if (done_id !== exp_d) $display("FAIL rr_done_id%0d: got %b want %b", nd, done_id, exp_d);
            else n_pass++;
            nd++;
         end
         step;
         if (ng >= 4) req = '0;
      end
      n_total++;
      if (ng != 4 || nd != 4) $display("FAIL rr_counts: got grants=%0d dones=%0d want 4/4", ng, nd);
      else n_pass++;
   endtask

   task automatic test_reset_wr;
      step;
      issue(0, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'h7);
      #1;
      n_total++;
      if (grant !== 2'b01) $display("FAIL rst_pre_grant: got %b want 01", grant); else n_pass++;
      step; req = '0;
      step;
      n_total++;
      if (mux_data_active !== 1'b1) $display("FAIL rst_in_wr: got %b want 1", mux_data_active);
      else n_pass++;
      #1 rst = 1'b1;
      #1;
      n_total++;
      if (mux_data_active !== 1'b0 || busy !== 1'b0 || rd_data !== 32'h0 || rd_attr !== 4'h0)
         $display("FAIL rst_async: got act=%b busy=%b rd=%h/%h want 0/0/0/0",
                  mux_data_active, busy, rd_data, rd_attr);
      else n_pass++;
      issue(1, 1'b1, 1'b1, 32'h0000_00B1, 4'hB);
      issue(0, 1'b1, 1'b0, 32'h0000_00B0, 4'hC);
      step;
      n_total++;
      if (done !== 1'b0 || grant !== 2'b00)
         $display("FAIL rst_hold: got done=%b grant=%b want 0/00", done, grant);
      else n_pass++;
      rst = 1'b0;
      #1;
      n_total++;
      if (grant !== 2'b01 || done !== 1'b0)
         $display("FAIL rst_first_grant: got grant=%b done=%b want 01/0", grant, done);
      else n_pass++;
      step; req = '0;
      step; step;
      n_total++;
      if (done !== 1'b1 || done_id !== 1'b0)
         $display("FAIL rst_after_done: got done=%b id=%b want 1/0", done, done_id);
      else n_pass++;
   endtask

   task automatic test_idle;
      step;
      for (int i = 0; i < 10; i++) begin
         step;
         n_total++;
         if ({busy, mux_sel_active, mux_data_active, mux_out_active, mux_data_in, mux_attr_in, grant} !== '0)
            $display("FAIL idle%0d: got busy=%b strobes=%b%b%b din=%h grant=%b want all 0", i,
                     busy, mux_sel_active, mux_data_active, mux_out_active, mux_data_in, grant);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset;
      test_write;
      test_write_read;
      test_isolation;
      test_contention;
      test_reset_wr;
      test_idle;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pu_multiplexer_sched.md
Name: pu_multiplexer_sched

Overview:
- Round-robin scheduler that shares one pu_multiplexer between NREQ requesters.
- Each requester issues whole transactions: write a slot (sel, data, attr) or read a slot.
- The block converts each transaction into the multiplexer's strobe sequence: sel_active, then data_active or out_active.
- Read results are captured and returned with a done pulse; sits between the processing-unit control logic and the multiplexer instance.

Parameters:
- DATA_WIDTH, 32, data bus width; must match the multiplexer.
- ATTR_WIDTH, 4, attribute width; must match the multiplexer.
- SEL_WIDTH, 1, slot index width; SEL_WIDTH <= DATA_WIDTH.
- NREQ, 2, number of requesters, >= 2.
- ID_WIDTH, 1, width of the requester index; must satisfy 2**ID_WIDTH >= NREQ.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester transaction request; held until granted.
- req_wr  in  NREQ  per-requester op: 1 = write, 0 = read.
- req_sel  in  NREQ*SEL_WIDTH  packed slot index; requester i at [i*SEL_WIDTH +: SEL_WIDTH].
- req_data  in  NREQ*DATA_WIDTH  packed write data.
- req_attr  in  NREQ*ATTR_WIDTH  packed write attr.
- grant  out  NREQ  one-hot, 1-cycle pulse; fields sampled on that edge.
- busy  out  1  high whenever state != IDLE.
- done  out  1  1-cycle pulse when a transaction completes.
- done_id  out  ID_WIDTH  requester index of the completed transaction; valid with done.
- rd_data  out  DATA_WIDTH  captured read data; held until the next read completes.
- rd_attr  out  ATTR_WIDTH  captured read attr; held likewise.
- mux_sel_active  out  1  multiplexer selector strobe.
- mux_data_active  out  1  multiplexer data write strobe.
- mux_out_active  out  1  multiplexer output enable.
- mux_data_in  out  DATA_WIDTH  multiplexer data_in.
- mux_attr_in  out  ATTR_WIDTH  multiplexer attr_in.
- mux_data_out  in  DATA_WIDTH  multiplexer data_out.
- mux_attr_out  in  ATTR_WIDTH  multiplexer attr_out.

Behaviour:
- Reset values (asynchronous, take effect immediately, independent of clk):
  - state = IDLE.
  - All strobes, grant, busy, done, done_id, rd_data, rd_attr, mux_data_in, mux_attr_in = 0.
  - RR pointer = NREQ-1, so requester 0 wins first.
- All mux_* outputs are registered; only the state drives them.
- FSM states IDLE, SEL, WR, RD, CAP:
  - IDLE:
    - If any req is high, pick the winner by round-robin starting at pointer+1 with wrap.
    - Assert grant[winner] for one cycle.
    - Latch winner's op, sel, data, attr and id; pointer <= winner; go to SEL.
    - If no req is high, stay in IDLE with no outputs.
  - SEL:
    - mux_sel_active = 1.
    - mux_data_in = latched sel zero-extended to DATA_WIDTH; mux_attr_in = 0.
    - Next state is WR if op = write, else RD.
  - WR:
    - mux_data_active = 1, mux_data_in = latched data, mux_attr_in = latched attr.
    - Next state IDLE; done = 1 and done_id = id in the following cycle.
  - RD:
    - mux_out_active = 1, mux_data_in = 0.
    - Next state CAP.
  - CAP:
    - All strobes 0.
    - The multiplexer output registered on the RD edge is valid during this cycle.
    - On the CAP->IDLE edge: rd_data <= mux_data_out, rd_attr <= mux_attr_out, done <= 1, done_id <= id.
- Latency, counted from the grant edge:
  - Write: 3 cycles per transaction; done 3 cycles after grant.
  - Read: 4 cycles per transaction; done 4 cycles after grant.
  - The IDLE arbitration cycle is never skipped.
- Outside SEL/WR, mux_data_in and mux_attr_in = 0.
- A req that drops before grant is ignored without side effects.
- req changes while busy do not affect the transaction in flight.
- Simultaneous requests are served strictly round-robin; a winner cannot be regranted while another requester is pending.
- done and grant may be high in the same cycle, when the next transaction is granted in IDLE just as done fires.
- Reset asserted mid-transaction:
  - Strobes drop immediately and the transaction is lost.
  - No done is generated.
  - rd_data and rd_attr are cleared.

Decomposition:
- A shared header holds the FSM state localparams (IDLE = 0, SEL = 1, WR = 2, RD = 3, CAP = 4; 3-bit) and the op encoding (OP_RD = 0, OP_WR = 1).
- One sub-module, pu_rr_arbiter (NREQ): inputs req, pointer, enable; output one-hot grant; purely combinational.
- FSM, latches and output registers stay in pu_multiplexer_sched.
- The bench instantiates pu_multiplexer_sched together with a real pu_multiplexer.

Test Plan:
- Write: req[0] write, sel 0, data 32'hAAAA_AAAA, attr 4'hA.
  - Required: grant[0] at cycle c.
  - mux_sel_active with mux_data_in = 0 at c+1.
  - mux_data_active with mux_data_in = AAAA_AAAA, mux_attr_in = A at c+2.
  - done with done_id = 0 at c+3.
- Write then read: req[1] write sel 1 = 32'h5555_5555/4'h5, then req[1] read sel 1.
  - Required: done at grant+4 with rd_data = 5555_5555, rd_attr = 5.
- Slot isolation: read sel 0 after both writes.
  - Required: rd_data = AAAA_AAAA, rd_attr = A.
  - rd_data/rd_attr hold until the next read, across an intervening write.
- Contention: req[0] and req[1] both high continuously for 4 writes.
  - Required: grant order 0, 1, 0, 1 and done_id order 0, 1, 0, 1.
  - Grants spaced 3 cycles apart.
- Reset during WR: assert rst between clock edges.
  - Required: mux_data_active = 0 before the next edge and no done.
  - After release with req[1] and req[0] high, first grant = 0.
- Idle hygiene: no req for 10 cycles.
  - Required: busy, all strobes, mux_data_in and grant stay 0.
